// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller and its bit sampler.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_t;

  localparam int unsigned PRESC_8       = 8;
  localparam int unsigned PRESC_16      = 16;
  localparam int unsigned PRESC_32      = 32;
  localparam int unsigned PRESC_DEFAULT = PRESC_8;

  // Anything other than a supported oversampling ratio falls back to 8x.
  function automatic int unsigned legal_prescale(input int unsigned p);
    return (p == PRESC_8 || p == PRESC_16 || p == PRESC_32) ? p : PRESC_DEFAULT;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Serial-line, configuration, counter and received-byte signals of the RX controller.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 6
);
  logic               RX_IN;
  logic               PAR_EN;
  logic               PAR_TYP;
  logic [PRESC_W-1:0] prescale;
  logic [4:0]         edge_cnt;
  logic [3:0]         bit_cnt;
  logic               cnt_enable;
  logic [PRESC_W-1:0] cnt_prescale;
  logic               cnt_par_en;
  logic [DATA_W-1:0]  P_DATA;
  logic               data_valid;
  logic               par_err;
  logic               stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, prescale, edge_cnt, bit_cnt,
    input  cnt_enable, cnt_prescale, cnt_par_en, P_DATA, data_valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, prescale, edge_cnt, bit_cnt,
    output cnt_enable, cnt_prescale, cnt_par_en, P_DATA, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/rx_bit_sampler.sv
// Takes three oversamples around the bit centre and majority-votes them;
// bit_rdy marks the cycle in which bit_val is the settled decision.
module rx_bit_sampler #(
  parameter int unsigned PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         edge_cnt,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               rx,
  output logic               bit_val,
  output logic               bit_rdy
);
  logic [4:0] half;
  logic [2:0] samples;

  assign half = 5'(prescale >> 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      samples <= '0;
    end else begin
      if (edge_cnt == half - 5'd1) samples[0] <= rx;
      if (edge_cnt == half)        samples[1] <= rx;
      if (edge_cnt == half + 5'd1) samples[2] <= rx;
    end
  end

  assign bit_val = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                   (samples[1] & samples[2]);
  assign bit_rdy = (edge_cnt == half + 5'd2);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, frame sequencing, LSB-first deserialisation,
// parity/stop checking and one-cycle result pulses; sequences an external edge/bit counter.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRESC_W = 6
) (
  input logic           clk,
  input logic           rst,
  uart_rx_ctrl_if.slave bus
);
  localparam logic [3:0] DATA_END = 4'(DATA_W + 1);
  localparam logic [3:0] PAR_END  = 4'(DATA_W + 2);

  rx_state_t         state;
  par_typ_t          par_typ_q;
  logic              rx_q;
  logic              perr_q;
  logic [DATA_W-1:0] shift;
  logic              bit_val;
  logic              bit_rdy;
  logic              start_det;
  logic              serr_now;
  logic              frame_ok;

  rx_bit_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk      (clk),
    .rst      (rst),
    .edge_cnt (bus.edge_cnt),
    .prescale (bus.cnt_prescale),
    .rx       (bus.RX_IN),
    .bit_val  (bit_val),
    .bit_rdy  (bit_rdy)
  );

  // Falling edge only: a line still low after a stop error cannot retrigger.
  assign start_det = rx_q & ~bus.RX_IN;
  assign serr_now  = ~bit_val;
  assign frame_ok  = ~perr_q & ~serr_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      par_typ_q        <= PAR_EVEN;
      rx_q             <= 1'b1;
      perr_q           <= 1'b0;
      shift            <= '0;
      bus.cnt_enable   <= 1'b0;
      bus.cnt_prescale <= PRESC_W'(PRESC_DEFAULT);
      bus.cnt_par_en   <= 1'b0;
      bus.P_DATA       <= '0;
      bus.data_valid   <= 1'b0;
      bus.par_err      <= 1'b0;
      bus.stp_err      <= 1'b0;
    end else begin
      rx_q           <= bus.RX_IN;
      bus.data_valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start_det) begin
            state            <= START;
            bus.cnt_enable   <= 1'b1;
            bus.cnt_prescale <= PRESC_W'(legal_prescale(32'(bus.prescale)));
            bus.cnt_par_en   <= bus.PAR_EN;
            par_typ_q        <= par_typ_t'(bus.PAR_TYP);
            perr_q           <= 1'b0;
          end
        end
        START: begin
          if (bit_rdy && bit_val) begin
            state          <= IDLE;
            bus.cnt_enable <= 1'b0;
          end else if (bus.bit_cnt == 4'd1) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_rdy) shift <= {bit_val, shift[DATA_W-1:1]};
          if (bus.bit_cnt == DATA_END) state <= bus.cnt_par_en ? PARITY : STOP;
        end
        PARITY: begin
          if (bit_rdy) perr_q <= bit_val ^ (^shift) ^ (par_typ_q == PAR_ODD);
          if (bus.bit_cnt == PAR_END) state <= STOP;
        end
        STOP: begin
          if (bit_rdy) begin
            bus.par_err    <= perr_q;
            bus.stp_err    <= serr_now;
            bus.data_valid <= frame_ok;
            if (frame_ok) bus.P_DATA <= shift;
            state          <= IDLE;
            bus.cnt_enable <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
